// File: rtl/jpeb_memory_map.sv
// ============================================================================
// Module   : jpeb_memory_map
// Brief    : Unified 16-bit word memory: RAM, framebuffer and PS/2 register,
//            two CPU read ports, one write port, one VGA pixel port.
//            Optional preload build: define MEM_INIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module jpeb_memory_map #(
  parameter int          RAM_AW   = 14,
  parameter logic [15:0] FB_BASE  = 16'hC000,
  parameter int          FB_W     = 80,
  parameter int          FB_H     = 60,
  parameter logic [15:0] PS2_ADDR = 16'hFFFF
`ifdef MEM_INIT_EN
  ,
  parameter string       INIT_FILE = "mem.hex"
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] raddr0,
  output logic [15:0] rdata0,
  input  logic        ren,
  input  logic [15:0] raddr1,
  output logic [15:0] rdata1,
  input  logic        wen,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  output logic        ps2_ren,
  input  logic [15:0] ps2_data_in,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [11:0] pixel
);

  localparam int          c_RAM_DEPTH = 1 << RAM_AW;
  localparam int          c_FB_DEPTH  = FB_W * FB_H;
  localparam int          c_FB_AW     = $clog2(c_FB_DEPTH);
  localparam logic [31:0] c_RAM_END   = 32'(c_RAM_DEPTH);
  localparam logic [31:0] c_FB_START  = 32'(FB_BASE);
  localparam logic [31:0] c_FB_END    = 32'(FB_BASE) + 32'(c_FB_DEPTH);
  localparam logic [9:0]  c_VIS_W     = 10'(FB_W * 8);
  localparam logic [9:0]  c_VIS_H     = 10'(FB_H * 8);

  localparam logic [1:0] c_SEL_NONE = 2'd0;
  localparam logic [1:0] c_SEL_RAM  = 2'd1;
  localparam logic [1:0] c_SEL_FB   = 2'd2;
  localparam logic [1:0] c_SEL_PS2  = 2'd3;

  function automatic logic [1:0] decode(input logic [15:0] a);
    logic [31:0] wa;
    wa = {16'd0, a};
    if (wa < c_RAM_END)                        return c_SEL_RAM;
    else if (wa >= c_FB_START && wa < c_FB_END) return c_SEL_FB;
    else if (a == PS2_ADDR)                      return c_SEL_PS2;
    else                                         return c_SEL_NONE;
  endfunction

  function automatic logic [c_FB_AW-1:0] fb_index(input logic [15:0] a);
    return c_FB_AW'(a - FB_BASE);
  endfunction

  function automatic logic [RAM_AW-1:0] ram_index(input logic [15:0] a);
    return RAM_AW'(a);
  endfunction

  // One bank per read port so each bank is a plain 1W1R block RAM.
  logic [15:0] r_ram_b0 [0:c_RAM_DEPTH-1];
  logic [15:0] r_ram_b1 [0:c_RAM_DEPTH-1];
  logic [15:0] r_fb_b0  [0:c_FB_DEPTH-1];
  logic [15:0] r_fb_b1  [0:c_FB_DEPTH-1];
  logic [11:0] r_fb_pix [0:c_FB_DEPTH-1];

  logic [1:0]  w_sel0, w_sel1, w_selw;
  logic        w_wr_ram, w_wr_fb;
  logic [15:0] r_ram0_q, r_ram1_q, r_fb0_q, r_fb1_q, r_ps20_q, r_ps21_q;
  logic [1:0]  r_sel0, r_sel1;
  logic [c_FB_AW-1:0] w_cell;
  logic        w_pix_vis;
  logic [11:0] r_pix_q;
  logic        r_pix_vld;

  assign w_sel0 = decode(raddr0);
  assign w_sel1 = decode(raddr1);
  assign w_selw = decode(waddr);

  assign ps2_ren = ren & (raddr1 == PS2_ADDR);

  // A write that coincides with reset being held is dropped.
  assign w_wr_ram = wen & reset & (w_selw == c_SEL_RAM);
  assign w_wr_fb  = wen & reset & (w_selw == c_SEL_FB);

`ifdef MEM_INIT_EN
  initial begin
    for (int i = 0; i < c_FB_DEPTH; i++) begin
      r_fb_b0[i]  = '0;
      r_fb_b1[i]  = '0;
      r_fb_pix[i] = '0;
    end
  end
`endif

  // Storage: non-blocking write plus registered read gives read-first.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram_b0[ram_index(waddr)] <= wdata;
      r_ram_b1[ram_index(waddr)] <= wdata;
    end
    r_ram0_q <= r_ram_b0[ram_index(raddr0)];
    if (ren) r_ram1_q <= r_ram_b1[ram_index(raddr1)];
  end

  always_ff @(posedge clk) begin
    if (w_wr_fb) begin
      r_fb_b0[fb_index(waddr)]  <= wdata;
      r_fb_b1[fb_index(waddr)]  <= wdata;
      r_fb_pix[fb_index(waddr)] <= wdata[11:0];
    end
    r_fb0_q <= r_fb_b0[fb_index(raddr0)];
    if (ren) r_fb1_q <= r_fb_b1[fb_index(raddr1)];
    r_pix_q <= r_fb_pix[w_cell];
  end

  always_ff @(posedge clk) begin
    r_ps20_q <= ps2_data_in;
    if (ren) r_ps21_q <= ps2_data_in;
  end

  // Source selects carry the reset, so outputs read 0 the moment reset drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel0    <= c_SEL_NONE;
      r_sel1    <= c_SEL_NONE;
      r_pix_vld <= 1'b0;
    end else begin
      r_sel0    <= w_sel0;
      if (ren) r_sel1 <= w_sel1;
      r_pix_vld <= w_pix_vis;
    end
  end

  assign w_pix_vis = (pixel_x < c_VIS_W) && (pixel_y < c_VIS_H);
  assign w_cell    = w_pix_vis
                   ? (c_FB_AW'(pixel_y >> 3) * c_FB_AW'(FB_W) + c_FB_AW'(pixel_x >> 3))
                   : '0;

  always_comb begin
    rdata0 = '0;
    case (r_sel0)
      c_SEL_RAM: rdata0 = r_ram0_q;
      c_SEL_FB:  rdata0 = r_fb0_q;
      c_SEL_PS2: rdata0 = r_ps20_q;
      default:   rdata0 = '0;
    endcase
  end

  always_comb begin
    rdata1 = '0;
    case (r_sel1)
      c_SEL_RAM: rdata1 = r_ram1_q;
      c_SEL_FB:  rdata1 = r_fb1_q;
      c_SEL_PS2: rdata1 = r_ps21_q;
      default:   rdata1 = '0;
    endcase
  end

  assign pixel = r_pix_vld ? r_pix_q : 12'd0;

endmodule

`default_nettype wire

// File: tb/tb_jpeb_memory_map.sv
// ============================================================================
// Module   : tb_jpeb_memory_map
// Brief    : Directed self-checking bench for jpeb_memory_map.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_jpeb_memory_map;

  logic        clk;
  logic        reset;
  logic [15:0] raddr0;
  logic [15:0] rdata0;
  logic        ren;
  logic [15:0] raddr1;
  logic [15:0] rdata1;
  logic        wen;
  logic [15:0] waddr;
  logic [15:0] wdata;
  logic        ps2_ren;
  logic [15:0] ps2_data_in;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic [11:0] pixel;

  int n_checks = 0;
  int n_fail   = 0;

  jpeb_memory_map dut (
    .clk         (clk),
    .reset       (reset),
    .raddr0      (raddr0),
    .rdata0      (rdata0),
    .ren         (ren),
    .raddr1      (raddr1),
    .rdata1      (rdata1),
    .wen         (wen),
    .waddr       (waddr),
    .wdata       (wdata),
    .ps2_ren     (ps2_ren),
    .ps2_data_in (ps2_data_in),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel       (pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    wen = 1'b1; waddr = a; wdata = d;
    step();
    wen = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; ren = 1'b1; raddr1 = 16'hFFFF;
    step();
    n_checks++; if (rdata0 !== 16'h0) begin n_fail++; $display("FAIL reset_rdata0 got %h want 0000", rdata0); end
    n_checks++; if (rdata1 !== 16'h0) begin n_fail++; $display("FAIL reset_rdata1 got %h want 0000", rdata1); end
    n_checks++; if (pixel !== 12'h0) begin n_fail++; $display("FAIL reset_pixel got %h want 000", pixel); end
    n_checks++; if (ps2_ren !== 1'b1) begin n_fail++; $display("FAIL reset_ps2_ren got %b want 1", ps2_ren); end
    ren = 1'b0; raddr1 = 16'h0;
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    do_write(16'h0010, 16'h1234);
    raddr0 = 16'h0010; raddr1 = 16'h0010; ren = 1'b1;
    step();
    ren = 1'b0;
    n_checks++; if (rdata0 !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_p0 got %h want 1234", rdata0); end
    n_checks++; if (rdata1 !== 16'h1234) begin n_fail++; $display("FAIL wr_rd_p1 got %h want 1234", rdata1); end
  endtask

  task automatic test_read_during_write();
    do_write(16'h0020, 16'h0001);
    raddr0 = 16'h0020; raddr1 = 16'h0020; ren = 1'b1;
    wen = 1'b1; waddr = 16'h0020; wdata = 16'hBEEF;
    step();
    wen = 1'b0;
    n_checks++; if (rdata1 !== 16'h0001) begin n_fail++; $display("FAIL rdw_old_p1 got %h want 0001", rdata1); end
    n_checks++; if (rdata0 !== 16'h0001) begin n_fail++; $display("FAIL rdw_old_p0 got %h want 0001", rdata0); end
    step();
    ren = 1'b0;
    n_checks++; if (rdata1 !== 16'hBEEF) begin n_fail++; $display("FAIL rdw_new_p1 got %h want beef", rdata1); end
    n_checks++; if (rdata0 !== 16'hBEEF) begin n_fail++; $display("FAIL rdw_new_p0 got %h want beef", rdata0); end
  endtask

  task automatic test_ps2();
    ps2_data_in = 16'h001C; ren = 1'b1; raddr1 = 16'hFFFF; raddr0 = 16'h0010;
    #1;
    n_checks++; if (ps2_ren !== 1'b1) begin n_fail++; $display("FAIL ps2_ren_hi got %b want 1", ps2_ren); end
    step();
    n_checks++; if (rdata1 !== 16'h001C) begin n_fail++; $display("FAIL ps2_rd got %h want 001c", rdata1); end
    ren = 1'b0; ps2_data_in = 16'h0055; raddr0 = 16'hFFFF;
    #1;
    n_checks++; if (ps2_ren !== 1'b0) begin n_fail++; $display("FAIL ps2_ren_lo got %b want 0", ps2_ren); end
    step();
    n_checks++; if (rdata1 !== 16'h001C) begin n_fail++; $display("FAIL ps2_hold got %h want 001c", rdata1); end
    n_checks++; if (rdata0 !== 16'h0055) begin n_fail++; $display("FAIL ps2_p0 got %h want 0055", rdata0); end
    ren = 1'b1; raddr1 = 16'hFFFE;
    #1;
    n_checks++; if (ps2_ren !== 1'b0) begin n_fail++; $display("FAIL ps2_ren_addr got %b want 0", ps2_ren); end
    ren = 1'b0;
  endtask

  task automatic test_pixel();
    do_write(16'hC000 + 16'd81, 16'h0F0F);
    do_write(16'hC000, 16'h1ABC);
    do_write(16'hC000 + 16'd4799, 16'h0777);
    pixel_x = 10'd8; pixel_y = 10'd8;
    step();
    n_checks++; if (pixel !== 12'hF0F) begin n_fail++; $display("FAIL pix_8_8 got %h want f0f", pixel); end
    pixel_x = 10'd15; pixel_y = 10'd15;
    step();
    n_checks++; if (pixel !== 12'hF0F) begin n_fail++; $display("FAIL pix_15_15 got %h want f0f", pixel); end
    pixel_x = 10'd0; pixel_y = 10'd0;
    step();
    n_checks++; if (pixel !== 12'hABC) begin n_fail++; $display("FAIL pix_0_0 got %h want abc", pixel); end
    pixel_x = 10'd639; pixel_y = 10'd479;
    step();
    n_checks++; if (pixel !== 12'h777) begin n_fail++; $display("FAIL pix_last got %h want 777", pixel); end
    pixel_x = 10'd640; pixel_y = 10'd8;
    step();
    n_checks++; if (pixel !== 12'h000) begin n_fail++; $display("FAIL pix_x640 got %h want 000", pixel); end
    pixel_x = 10'd8; pixel_y = 10'd480;
    step();
    n_checks++; if (pixel !== 12'h000) begin n_fail++; $display("FAIL pix_y480 got %h want 000", pixel); end
    raddr1 = 16'hC000; ren = 1'b1; raddr0 = 16'hC000 + 16'd81;
    step();
    ren = 1'b0;
    n_checks++; if (rdata1 !== 16'h1ABC) begin n_fail++; $display("FAIL fb_cpu_p1 got %h want 1abc", rdata1); end
    n_checks++; if (rdata0 !== 16'h0F0F) begin n_fail++; $display("FAIL fb_cpu_p0 got %h want 0f0f", rdata0); end
    pixel_x = 10'd8; pixel_y = 10'd8;
  endtask

  task automatic test_unmapped();
    do_write(16'h8000, 16'hAAAA);
    do_write(16'hC000 + 16'd4800, 16'h5555);
    do_write(16'h3FFF, 16'h7E57);
    do_write(16'h4000, 16'h6666);
    do_write(16'hFFFF, 16'h9999);
    raddr0 = 16'h8000; raddr1 = 16'hC000 + 16'd4800; ren = 1'b1;
    step();
    n_checks++; if (rdata0 !== 16'h0) begin n_fail++; $display("FAIL unm_8000 got %h want 0000", rdata0); end
    n_checks++; if (rdata1 !== 16'h0) begin n_fail++; $display("FAIL unm_fb_end got %h want 0000", rdata1); end
    raddr0 = 16'h3FFF; raddr1 = 16'h4000;
    step();
    n_checks++; if (rdata0 !== 16'h7E57) begin n_fail++; $display("FAIL ram_top got %h want 7e57", rdata0); end
    n_checks++; if (rdata1 !== 16'h0) begin n_fail++; $display("FAIL unm_4000 got %h want 0000", rdata1); end
    ps2_data_in = 16'h0042; raddr1 = 16'hFFFF;
    step();
    ren = 1'b0;
    n_checks++; if (rdata1 !== 16'h0042) begin n_fail++; $display("FAIL ps2_wr_ignored got %h want 0042", rdata1); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp;
    for (int i = 0; i < 4; i++) do_write(16'h0100 + 16'(i), 16'hA000 + 16'(i * 16'h111));
    for (int i = 0; i < 4; i++) begin
      raddr0 = 16'h0100 + 16'(i);
      step();
      exp = 16'hA000 + 16'(i * 16'h111);
      n_checks++; if (rdata0 !== exp) begin n_fail++; $display("FAIL b2b_%0d got %h want %h", i, rdata0, exp); end
    end
  endtask

  task automatic test_reset_mid();
    raddr0 = 16'h0010; raddr1 = 16'h0020; ren = 1'b1; pixel_x = 10'd8; pixel_y = 10'd8;
    step();
    ren = 1'b0;
    wen = 1'b1; waddr = 16'h0010; wdata = 16'hDEAD;
    reset = 1'b0;
    #1;
    n_checks++; if (rdata0 !== 16'h0) begin n_fail++; $display("FAIL mid_rst_rdata0 got %h want 0000", rdata0); end
    n_checks++; if (rdata1 !== 16'h0) begin n_fail++; $display("FAIL mid_rst_rdata1 got %h want 0000", rdata1); end
    n_checks++; if (pixel !== 12'h0) begin n_fail++; $display("FAIL mid_rst_pixel got %h want 000", pixel); end
    step();
    wen = 1'b0;
    reset = 1'b1;
    #1;
    n_checks++; if (rdata0 !== 16'h0) begin n_fail++; $display("FAIL post_rel_early got %h want 0000", rdata0); end
    step();
    n_checks++; if (rdata0 !== 16'h1234) begin n_fail++; $display("FAIL post_rel_data got %h want 1234", rdata0); end
    n_checks++; if (pixel !== 12'hF0F) begin n_fail++; $display("FAIL post_rel_pixel got %h want f0f", pixel); end
  endtask

  initial begin
    reset = 1'b0; raddr0 = '0; ren = 1'b0; raddr1 = '0; wen = 1'b0;
    waddr = '0; wdata = '0; ps2_data_in = '0; pixel_x = '0; pixel_y = '0;
    test_reset();
    test_write_read();
    test_read_during_write();
    test_ps2();
    test_pixel();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
